fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the pipelined MIPS core. It replaces the purely combinational EX-stage forwarding logic. It keeps its own shadow pipeline of destination tags (EX slot plus `FWD_STAGES` later stages), so the datapath only presents the instruction leaving ID. From that state it produces per-operand forward selects for EX, a load-use stall for the IF/ID front end, and a saturating stall counter.

## Interface
- `REG_AW`, 5, register address width.
- `NUM_SRC`, 2, source operands per instruction (rs, rt, ...).
- `FWD_STAGES`, 2, post-EX stages that can forward (1 = EX/MEM, 2 = MEM/WB, ...).
- `LOAD_LAT`, 1, stages after EX before load data is forwardable. Constraint: `1 <= LOAD_LAT < FWD_STAGES`.
- `SEL_W`, `$clog2(FWD_STAGES+1)`, derived forward select width.

Ports:
- `clk`, in, 1, single clock, rising edge.
- `reset`, in, 1, asynchronous, active-high; clears all state.
- `hold`, in, 1, global pipeline freeze (e.g. memory wait); all tag state and the counter hold.
- `flush`, in, 1, squash the instruction currently in ID.
- `id_valid`, in, 1, ID holds a real instruction.
- `id_src`, in, `NUM_SRC*REG_AW`, ID source register numbers; operand i is at bits `[i*REG_AW +: REG_AW]`.
- `id_rd`, in, `REG_AW`, ID destination register.
- `id_regwrite`, in, 1, ID instruction writes `id_rd`.
- `id_memread`, in, 1, ID instruction is a load.
- `stall`, out, 1, freeze PC and IF/ID; a bubble enters EX.
- `fwd_sel`, out, `NUM_SRC*SEL_W`, per-operand EX mux select. 0 selects the register file; k selects the result of post-EX stage k.
- `stall_count`, out, 16, saturating count of stall cycles.

## Operation
- **Tag pipeline.** Slot E (EX) holds the src list, rd, rw and ld. Slots S1..S`FWD_STAGES` hold rd, rw and ld.
- **Advance** (every edge with `hold`=0): S(k+1)←S(k), S1←E.
- **E load:**
  - `flush`=1, `stall`=1 or `id_valid`=0: E←bubble (rw=0, ld=0, src=0).
  - Otherwise: E←ID fields.
- **Hold.** `hold`=1 freezes every slot and `stall_count`. The `stall` and `fwd_sel` outputs are still driven.
- **Forward select**, per operand i of slot E:
  - A candidate stage k must satisfy: S(k).rw=1, S(k).rd≠0, S(k).rd==E.src[i], and not (S(k).ld=1 and k≤LOAD_LAT).
  - `fwd_sel[i]` is the smallest candidate k, so the youngest result wins; it is 0 if there is no candidate.
  - A source of register 0 always gives 0.
- **Load-use stall.** `stall`=1 when `id_valid`=1, `flush`=0, and some ID source s≠0 matches a live load that will not be forwardable when the ID instruction reaches EX next cycle:
  - E.ld=1 and E.rw=1 and E.rd==s; or
  - S(j).ld=1 and S(j).rw=1 and S(j).rd==s, for j < LOAD_LAT.
- **Stall length.** A load at E costs exactly `LOAD_LAT` stall cycles. No counter is needed; bubbles advance the load naturally.
- **Stall counter.** `stall_count` increments on every edge with `stall`=1 and `hold`=0. It saturates at 16'hFFFF.
- **Flush and stall together.** Flush wins: `stall`=0, and a bubble enters E.

## Timing
- `fwd_sel` is combinational from registered slots only. It is valid for the whole cycle the consumer is in EX, with zero extra latency.
- `stall` is combinational from the `id_*` inputs, `flush` and the registered slots. It must settle before the PC/IF-ID enable in the same cycle.
- Slot state updates on the rising edge of `clk`.
- On `reset` assertion, asynchronously: all slots become bubbles, `fwd_sel`=0, `stall`=0, `stall_count`=0.
- Reset mid-stall drops the pending stall immediately. The first edge after release behaves as from an empty pipeline.

## Structure
- **Package `fwd_pkg`:**
  - `FWD_RF` = 0 select constant.
  - Tag struct: rd, rw, ld.
  - EX-slot struct: tag plus src array.
  - `fwd_sel` / `id_src` slice helper functions.
- **Sub-module `fwd_tag_pipe`:** the slot register chain with hold, bubble insert and async reset, instantiated once. Match/priority logic and the counter stay in the top module.

## Test plan
1. **ALU back-to-back.** `add $3,$1,$2` then `sub $4,$3,$5` → `fwd_sel[0]`=1 while sub is in EX; `stall` never asserts.
2. **Two-back producer and priority.**
   - Distance-2 producer of $3 → `fwd_sel`=2.
   - Writes to $3 at both distance 1 and distance 2 → `fwd_sel`=1.
3. **Load-use, LOAD_LAT=1.** `lw $8` then `add` reading $8 → one cycle with `stall`=1 and a bubble in EX; then `fwd_sel`=2 for the add; `stall_count`=1.
4. **Load-use, LOAD_LAT=2, FWD_STAGES=3.** Load then dependent instruction → exactly 2 stall cycles, then `fwd_sel`=3.
5. **Register 0.** Producer writes $0, consumer reads $0 → `fwd_sel`=0, no stall.
6. **Flush, hold and reset.**
   - `flush` during a load-use match → `stall`=0 and a bubble enters E.
   - `hold`=1 for 3 cycles mid-stall → slots and counter frozen.
   - `reset` pulse → all outputs 0 asynchronously.

Source files
------------

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared tag types, select constant and operand field helper for the forwarding unit
package fwd_pkg;
  localparam int MAX_AW = 5;
  localparam int MAX_SRC = 2;
  localparam int SRC_W = MAX_SRC * MAX_AW;
  localparam int FWD_RF = 0;
  typedef struct packed {
    logic [MAX_AW-1:0] rd;
    logic              rw;
    logic              ld;
  } tag_t;
  typedef struct packed {
    tag_t                             tag;
    logic [MAX_SRC-1:0][MAX_AW-1:0]   src;
  } ex_t;
  function automatic logic [MAX_AW-1:0] field(input logic [SRC_W-1:0] v, input int i, input int w);
    logic [SRC_W-1:0] f;
    f = (v >> (i * w)) & ~({SRC_W{1'b1}} << w);
    return f[MAX_AW-1:0];
  endfunction
endpackage

// File: rtl/fwd_hazard_unit_tag_pipe.sv
// fwd_tag_pipe: EX slot plus post-EX tag chain with hold, bubble insert and async reset
module fwd_tag_pipe
  import fwd_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             bubble,
  input  ex_t              e_in,
  output ex_t              e,
  output tag_t [STAGES:1]  s
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e <= '0;
      s <= '0;
    end else if (!hold) begin
      e    <= bubble ? '0 : e_in;
      s[1] <= e.tag;
      for (int k = 2; k <= STAGES; k++) s[k] <= s[k-1];
    end
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: per-operand EX forward selects, load-use stall and saturating stall counter
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW     = MAX_AW,
  parameter int NUM_SRC    = MAX_SRC,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic                      id_memread,
  output logic                      stall,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic [15:0]               stall_count
);
  ex_t                   e_in;
  ex_t                   e;
  tag_t [FWD_STAGES:1]   s;
  logic                  hit;
  always_comb begin
    e_in        = '0;
    e_in.tag.rd = MAX_AW'(id_rd);
    e_in.tag.rw = id_regwrite;
    e_in.tag.ld = id_memread;
    for (int i = 0; i < NUM_SRC; i++) e_in.src[i] = field(SRC_W'(id_src), i, REG_AW);
  end
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (e_in.src[i] != '0) begin
        hit = hit | (e.tag.ld && e.tag.rw && e.tag.rd == e_in.src[i]);
        for (int j = 1; j < LOAD_LAT; j++) hit = hit | (s[j].ld && s[j].rw && s[j].rd == e_in.src[i]);
      end
    end
  end
  assign stall = id_valid && !flush && hit;
  always_comb begin
    fwd_sel = {NUM_SRC{SEL_W'(FWD_RF)}};
    for (int i = 0; i < NUM_SRC; i++)
      for (int k = FWD_STAGES; k >= 1; k--)
        if (s[k].rw && s[k].rd != '0 && s[k].rd == e.src[i] && !(s[k].ld && k <= LOAD_LAT))
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_count <= '0;
    else if (!hold && stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end
  fwd_tag_pipe #(.STAGES(FWD_STAGES)) u_pipe (
    .clk    (clk),
    .reset  (reset),
    .hold   (hold),
    .bubble (flush || stall || !id_valid),
    .e_in   (e_in),
    .e      (e),
    .s      (s)
  );
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed vectors against an instruction-history model for two configurations
module tb_fwd_hazard_unit;
  typedef struct packed {
    logic       v;
    logic [4:0] s1;
    logic [4:0] s0;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
  } ins_t;
  localparam int FA = 2, LA = 1, FB = 3, LB = 2;
  logic clk = 1'b0, reset = 1'b1, hold = 1'b0, flush = 1'b0;
  ins_t ia = '0, ib = '0;
  logic sa, sb;
  logic [3:0] fa, fb;
  logic [15:0] ca, cb;
  ins_t [3:0] ma = '0, mb = '0;
  logic [15:0] cma = '0, cmb = '0;
  int n_chk = 0, n_ok = 0;
  fwd_hazard_unit #(.FWD_STAGES(FA), .LOAD_LAT(LA)) dut_a (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(ia.v),
    .id_src({ia.s1, ia.s0}), .id_rd(ia.rd), .id_regwrite(ia.rw), .id_memread(ia.ld),
    .stall(sa), .fwd_sel(fa), .stall_count(ca)
  );
  fwd_hazard_unit #(.FWD_STAGES(FB), .LOAD_LAT(LB)) dut_b (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(ib.v),
    .id_src({ib.s1, ib.s0}), .id_rd(ib.rd), .id_regwrite(ib.rw), .id_memread(ib.ld),
    .stall(sb), .fwd_sel(fb), .stall_count(cb)
  );
  initial forever #5 clk = ~clk;
  function automatic ins_t ins(input int rd, input int s0, input int s1, input bit rw, input bit ld);
    return {1'b1, 5'(s1), 5'(s0), 5'(rd), rw, ld};
  endfunction
  // m[0] is the instruction in EX, m[d] the one d stages past EX
  function automatic logic [1:0] exp_sel(input ins_t [3:0] m, input int fs, input int ll, input logic [4:0] src);
    for (int k = 1; k <= fs; k++)
      if (src != 0 && m[k].rw && m[k].rd == src && !(m[k].ld && k <= ll)) return 2'(k);
    return 2'd0;
  endfunction
  // a load d stages past EX is usable next cycle only if it will then be more than ll stages past EX
  function automatic logic exp_stall(input ins_t [3:0] m, input int ll, input ins_t x, input logic fl);
    if (!x.v || fl) return 1'b0;
    for (int d = 0; d + 1 <= ll; d++)
      if (m[d].ld && m[d].rw && ((x.s0 != 0 && m[d].rd == x.s0) || (x.s1 != 0 && m[d].rd == x.s1))) return 1'b1;
    return 1'b0;
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s got %0d expected %0d", nm, got, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ma <= '0; mb <= '0; cma <= '0; cmb <= '0;
    end else if (!hold) begin
      ma <= {ma[2:0], (exp_stall(ma, LA, ia, flush) || flush || !ia.v) ? ins_t'('0) : ia};
      mb <= {mb[2:0], (exp_stall(mb, LB, ib, flush) || flush || !ib.v) ? ins_t'('0) : ib};
      if (exp_stall(ma, LA, ia, flush) && cma != 16'hFFFF) cma <= cma + 16'd1;
      if (exp_stall(mb, LB, ib, flush) && cmb != 16'hFFFF) cmb <= cmb + 16'd1;
    end
  end
  always @(negedge clk) begin
    chk("a_stall", 32'(sa), 32'(exp_stall(ma, LA, ia, flush)));
    chk("a_sel0", 32'(fa[1:0]), 32'(exp_sel(ma, FA, LA, ma[0].s0)));
    chk("a_sel1", 32'(fa[3:2]), 32'(exp_sel(ma, FA, LA, ma[0].s1)));
    chk("a_cnt", 32'(ca), 32'(cma));
    chk("b_stall", 32'(sb), 32'(exp_stall(mb, LB, ib, flush)));
    chk("b_sel0", 32'(fb[1:0]), 32'(exp_sel(mb, FB, LB, mb[0].s0)));
    chk("b_sel1", 32'(fb[3:2]), 32'(exp_sel(mb, FB, LB, mb[0].s1)));
    chk("b_cnt", 32'(cb), 32'(cmb));
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_a", 32'({sa, fa, ca}), 0);
    chk("rst_b", 32'({sb, fb, cb}), 0);
    ia = ins(3, 1, 2, 1, 0); cyc();
    ia = ins(4, 3, 5, 1, 0); cyc();
    chk("t1_sel", 32'(fa[1:0]), 1);
    chk("t1_stall", 32'(sa), 0);
    ia = '0; repeat (3) cyc();
    ia = ins(3, 1, 2, 1, 0); cyc();
    ia = ins(7, 0, 0, 0, 0); cyc();
    ia = ins(4, 3, 5, 1, 0); cyc();
    chk("t2_dist2", 32'(fa[1:0]), 2);
    ia = ins(3, 1, 2, 1, 0); cyc();
    ia = ins(3, 6, 6, 1, 0); cyc();
    ia = ins(4, 5, 3, 1, 0); cyc();
    chk("t2_prio", 32'(fa), 32'(4'b0100));
    ia = '0; repeat (3) cyc();
    ia = ins(8, 0, 0, 1, 1); cyc();
    ia = ins(9, 8, 1, 1, 0);
    #1 chk("t3_stall", 32'(sa), 1);
    cyc();
    chk("t3_stall_off", 32'(sa), 0);
    chk("t3_cnt", 32'(ca), 1);
    cyc();
    chk("t3_sel", 32'(fa[1:0]), 2);
    ia = '0; repeat (3) cyc();
    ia = ins(0, 1, 2, 1, 0); cyc();
    ia = ins(4, 0, 0, 1, 0); cyc();
    chk("t5_sel", 32'(fa), 0);
    ia = ins(0, 0, 0, 1, 1); cyc();
    ia = ins(5, 0, 0, 1, 0);
    #1 chk("t5_nostall", 32'(sa), 0);
    ia = '0; repeat (3) cyc();
    ia = ins(8, 0, 0, 1, 1); cyc();
    ia = ins(9, 8, 0, 1, 0); flush = 1'b1;
    #1 chk("t6_flush_stall", 32'(sa), 0);
    cyc();
    flush = 1'b0; ia = '0;
    chk("t6_flush_cnt", 32'(ca), 1);
    repeat (2) cyc();
    ia = ins(10, 0, 0, 1, 1); cyc();
    ia = ins(11, 10, 0, 1, 0);
    #1 chk("t6_hold_stall", 32'(sa), 1);
    hold = 1'b1;
    repeat (3) cyc();
    chk("t6_hold_cnt", 32'(ca), 1);
    chk("t6_hold_stall2", 32'(sa), 1);
    hold = 1'b0;
    cyc();
    chk("t6_cnt_after", 32'(ca), 2);
    chk("t6_stall_after", 32'(sa), 0);
    ia = '0; repeat (3) cyc();
    ia = ins(3, 1, 2, 1, 0); cyc();
    ia = ins(11, 3, 0, 1, 1); cyc();
    ia = ins(12, 11, 0, 1, 0);
    #1;
    chk("t6_pre_sel", 32'(fa[1:0]), 1);
    chk("t6_pre_stall", 32'(sa), 1);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_sel", 32'(fa), 0);
    chk("t6_rst_stall", 32'(sa), 0);
    chk("t6_rst_cnt", 32'(ca), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("t6_post_rst", 32'(sa), 0);
    ia = '0; repeat (2) cyc();
    ib = ins(8, 0, 0, 1, 1); cyc();
    ib = ins(9, 8, 0, 1, 0);
    #1 chk("t4_stall1", 32'(sb), 1);
    cyc();
    chk("t4_stall2", 32'(sb), 1);
    chk("t4_cnt1", 32'(cb), 1);
    cyc();
    chk("t4_stall_end", 32'(sb), 0);
    chk("t4_cnt", 32'(cb), 2);
    cyc();
    chk("t4_sel", 32'(fb[1:0]), 3);
    ib = '0; repeat (3) cyc();
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
